io_bridge_demux: RTL and testbench



---
 rtl/io_pkg.sv | 23 ++
 rtl/io_addr_decoder.sv | 33 +++
 rtl/io_bridge_demux.sv | 142 ++++++++++++++
 tb/tb_io_bridge_demux.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ============================================================================
// io_pkg : shared types and constants for the memory-mapped I/O bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

package io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } io_state_e;

   localparam logic [31:0] DEFAULT_DEV0_BASE = 32'h0000_7F00;
   localparam logic [31:0] DEFAULT_DEV1_BASE = 32'h0000_7F10;

   localparam int unsigned DEV_TIMER0 = 0;
   localparam int unsigned DEV_TIMER1 = 1;

endpackage

`default_nettype wire

// File: rtl/io_addr_decoder.sv
// ============================================================================
// io_addr_decoder : maps a byte address onto one of the two 16-byte device windows
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_addr_decoder
   import io_pkg::*;
#(
   parameter logic [31:0] DEV0_BASE = DEFAULT_DEV0_BASE,
   parameter logic [31:0] DEV1_BASE = DEFAULT_DEV1_BASE
) (
   input  logic [31:0] cpu_addr,
   output logic        hit,
   output logic        sel
);

   logic hit0;
   logic hit1;
   logic unused_offset;

   assign hit0 = (cpu_addr[31:4] == DEV0_BASE[31:4]);
   assign hit1 = (cpu_addr[31:4] == DEV1_BASE[31:4]);

   // Device 0 wins if the two windows were ever configured to overlap.
   assign hit = hit0 | hit1;
   assign sel = hit1 & ~hit0;

   assign unused_offset = ^cpu_addr[3:0];

endmodule

`default_nettype wire

// File: rtl/io_bridge_demux.sv
// ============================================================================
// io_bridge_demux : splits one CPU load/store into a one-hot device request and
// returns the device read data, with unmapped-address and timeout errors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_bridge_demux
   import io_pkg::*;
#(
   parameter logic [31:0] DEV0_BASE = DEFAULT_DEV0_BASE,
   parameter logic [31:0] DEV1_BASE = DEFAULT_DEV1_BASE,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  dev_req,
   output logic        dev_we,
   output logic [1:0]  dev_addr,
   output logic [31:0] dev_wdata,
   input  logic [31:0] dev0_rdata,
   input  logic [31:0] dev1_rdata,
   input  logic [1:0]  dev_ack
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   io_state_e   state;
   io_state_e   state_nx;
   logic        target;
   logic        target_nx;
   logic [7:0]  cnt;
   logic [7:0]  cnt_nx;
   logic [7:0]  cnt_inc;
   logic        we_nx;
   logic [1:0]  addr_nx;
   logic [31:0] wdata_nx;
   logic [31:0] rdata_nx;
   logic        err_nx;
   logic        dec_hit;
   logic        dec_sel;
   logic        tgt_ack;
   logic [31:0] tgt_rdata;

   io_addr_decoder #(
      .DEV0_BASE (DEV0_BASE),
      .DEV1_BASE (DEV1_BASE)
   ) u_dec (
      .cpu_addr (cpu_addr),
      .hit      (dec_hit),
      .sel      (dec_sel)
   );

   // Only the latched target's ack and data matter; the other device is ignored.
   assign tgt_ack   = (target == 1'(DEV_TIMER1)) ? dev_ack[DEV_TIMER1] : dev_ack[DEV_TIMER0];
   assign tgt_rdata = (target == 1'(DEV_TIMER1)) ? dev1_rdata : dev0_rdata;
   assign cnt_inc   = cnt + 8'd1;

   always_comb begin
      state_nx  = state;
      target_nx = target;
      cnt_nx    = cnt;
      we_nx     = dev_we;
      addr_nx   = dev_addr;
      wdata_nx  = dev_wdata;
      rdata_nx  = cpu_rdata;
      err_nx    = cpu_err;
      case (state)
         ST_IDLE: begin
            if (cpu_req) begin
               if (dec_hit) begin
                  target_nx = dec_sel;
                  we_nx     = cpu_we;
                  addr_nx   = cpu_addr[3:2];
                  wdata_nx  = cpu_wdata;
                  cnt_nx    = 8'd0;
                  state_nx  = ST_ACCESS;
               end else begin
                  err_nx   = 1'b1;
                  rdata_nx = 32'd0;
                  state_nx = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            if (tgt_ack) begin
               rdata_nx = dev_we ? 32'd0 : tgt_rdata;
               err_nx   = 1'b0;
               state_nx = ST_RESP;
            end else begin
               cnt_nx = cnt_inc;
               if (cnt_inc == TIMEOUT_CNT) begin
                  err_nx   = 1'b1;
                  rdata_nx = 32'd0;
                  state_nx = ST_RESP;
               end
            end
         end
         ST_RESP:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         target    <= 1'b0;
         cnt       <= 8'd0;
         dev_we    <= 1'b0;
         dev_addr  <= 2'd0;
         dev_wdata <= 32'd0;
         cpu_rdata <= 32'd0;
         cpu_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         target    <= target_nx;
         cnt       <= cnt_nx;
         dev_we    <= we_nx;
         dev_addr  <= addr_nx;
         dev_wdata <= wdata_nx;
         cpu_rdata <= rdata_nx;
         cpu_err   <= err_nx;
      end
   end

   // Decoded from the async-reset state register, so reset drops it immediately.
   assign dev_req   = (state != ST_ACCESS) ? 2'b00 :
                      (target ? 2'b10 : 2'b01);
   assign cpu_done  = (state == ST_RESP);
   assign cpu_stall = ~reset & (((state == ST_IDLE) & cpu_req) | (state == ST_ACCESS));

endmodule

`default_nettype wire

// File: tb/tb_io_bridge_demux.sv
// ============================================================================
// tb_io_bridge_demux : transaction-timeline model of the I/O bridge, randomized
// and directed accesses compared against the DUT on every cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_bridge_demux;

   localparam int          TO = 15;
   localparam logic [31:0] B0 = 32'h0000_7F00;
   localparam logic [31:0] B1 = 32'h0000_7F10;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;
   logic [1:0]  dev_req;
   logic        dev_we;
   logic [1:0]  dev_addr;
   logic [31:0] dev_wdata;
   logic [31:0] dev0_rdata;
   logic [31:0] dev1_rdata;
   logic [1:0]  dev_ack;

   io_bridge_demux #(
      .DEV0_BASE (B0),
      .DEV1_BASE (B1),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .cpu_done   (cpu_done),
      .cpu_err    (cpu_err),
      .cpu_rdata  (cpu_rdata),
      .dev_req    (dev_req),
      .dev_we     (dev_we),
      .dev_addr   (dev_addr),
      .dev_wdata  (dev_wdata),
      .dev0_rdata (dev0_rdata),
      .dev1_rdata (dev1_rdata),
      .dev_ack    (dev_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Expected outputs for the current cycle.
   logic        e_stall, e_done, e_err, e_we;
   logic [31:0] e_rdata, e_wdata;
   logic [1:0]  e_req, e_addr;

   // Model of everything that persists between transactions.
   logic        m_err, m_we;
   logic [31:0] m_rdata, m_wdata;
   logic [1:0]  m_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
         chk("cpu_done",  32'(cpu_done),  32'(e_done));
         chk("cpu_err",   32'(cpu_err),   32'(e_err));
         chk("cpu_rdata", cpu_rdata,      e_rdata);
         chk("dev_req",   32'(dev_req),   32'(e_req));
         chk("dev_we",    32'(dev_we),    32'(e_we));
         chk("dev_addr",  32'(dev_addr),  32'(e_addr));
         chk("dev_wdata", dev_wdata,      e_wdata);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_dev(input bit fix, input logic [31:0] v);
      dev0_rdata = fix ? v : $urandom;
      dev1_rdata = fix ? v : $urandom;
   endtask

   task automatic hold_exp();
      e_err   = m_err;
      e_rdata = m_rdata;
      e_we    = m_we;
      e_addr  = m_addr;
      e_wdata = m_wdata;
   endtask

   task automatic idle(input int n, input bit force_ack, input logic [1:0] ack_val);
      for (int i = 0; i < n; i++) begin
         cpu_req   = 1'b0;
         cpu_we    = 1'($urandom);
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         dev_ack   = force_ack ? ack_val : 2'($urandom);
         rand_dev(1'b0, 32'd0);
         e_stall = 1'b0; e_done = 1'b0; e_req = 2'b00;
         hold_exp();
         nxt();
      end
   endtask

   // One CPU access, starting in an IDLE cycle. ack_at = index of the ACCESS
   // cycle in which the target acks; ack_at >= TO means it never acks.
   task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                      input int ack_at, input bit fix, input logic [31:0] rdv,
                      input bit other_on, output int req_cycles, output int done_at,
                      output logic [1:0] req_seen, output logic [31:0] got_rdata,
                      output logic got_err);
      bit          hit0, hit1, hit, acked;
      int          tgt, n_access, cyc;
      logic [31:0] captured;
      logic [1:0]  a;
      hit0     = (addr[31:4] == B0[31:4]);
      hit1     = (addr[31:4] == B1[31:4]);
      hit      = hit0 || hit1;
      tgt      = hit0 ? 0 : 1;
      acked    = hit && (ack_at < TO);
      n_access = !hit ? 0 : (acked ? ack_at + 1 : TO);
      captured = 32'd0;
      req_cycles = 0; done_at = -1; req_seen = 2'b00; got_rdata = 32'd0; got_err = 1'b0;
      cyc = 0;

      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      dev_ack = 2'($urandom);
      rand_dev(fix, rdv);
      e_stall = 1'b1; e_done = 1'b0; e_req = 2'b00;
      hold_exp();
      #3;
      if (dev_req != 2'b00) req_cycles++;
      if (cpu_done) done_at = cyc;
      req_seen |= dev_req;
      nxt();
      cyc++;
      if (hit) begin
         m_we = we; m_addr = addr[3:2]; m_wdata = wd;
      end

      for (int c = 0; c < n_access; c++) begin
         rand_dev(fix, rdv);
         a[tgt]     = acked && (c == ack_at);
         a[1 - tgt] = other_on ? 1'b1 : 1'($urandom);
         dev_ack    = a;
         if (acked && c == ack_at) captured = (tgt == 1) ? dev1_rdata : dev0_rdata;
         e_stall = 1'b1; e_done = 1'b0; e_req = (tgt == 1) ? 2'b10 : 2'b01;
         hold_exp();
         #3;
         if (dev_req != 2'b00) req_cycles++;
         if (cpu_done && done_at < 0) done_at = cyc;
         req_seen |= dev_req;
         nxt();
         cyc++;
      end

      m_err   = !acked;
      m_rdata = (acked && !we) ? captured : 32'd0;
      dev_ack = 2'($urandom);
      rand_dev(1'b0, 32'd0);
      e_stall = 1'b0; e_done = 1'b1; e_req = 2'b00;
      hold_exp();
      #3;
      if (dev_req != 2'b00) req_cycles++;
      if (cpu_done && done_at < 0) done_at = cyc;
      req_seen |= dev_req;
      got_rdata = cpu_rdata;
      got_err   = cpu_err;
      nxt();
   endtask

   initial begin
      int          rc, da;
      logic [1:0]  rs;
      logic [31:0] gr;
      logic        ge;
      logic [31:0] ad;
      int          cls, ack_at, r;

      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dev0_rdata = 32'd0; dev1_rdata = 32'd0; dev_ack = 2'b00;
      m_err = 1'b0; m_we = 1'b0; m_rdata = 32'd0; m_wdata = 32'd0; m_addr = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_done",  32'(cpu_done),  32'd0);
      chk("rst_req",   32'(dev_req),   32'd0);
      chk("rst_rdata", cpu_rdata,      32'd0);
      chk("rst_wdata", dev_wdata,      32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;
      idle(2, 1'b0, 2'b00);

      // Load from dev0 word 1, ack one cycle after the request appears.
      txn(32'h0000_7F04, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, rc, da, rs, gr, ge);
      chk("t1_rdata", gr, 32'hDEAD_BEEF);
      chk("t1_err", 32'(ge), 32'd0);
      chk("t1_done_at", 32'(da), 32'd3);
      chk("t1_req_seen", 32'(rs), 32'h1);
      chk("t1_dev_addr", 32'(dev_addr), 32'd1);
      idle(2, 1'b0, 2'b00);

      // Store to dev1 word 2.
      txn(32'h0000_7F18, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0, rc, da, rs, gr, ge);
      chk("t2_rdata", gr, 32'h0);
      chk("t2_err", 32'(ge), 32'd0);
      chk("t2_req_seen", 32'(rs), 32'h2);
      chk("t2_dev_wdata", dev_wdata, 32'h1234_5678);
      chk("t2_dev_we", 32'(dev_we), 32'd1);
      chk("t2_dev_addr", 32'(dev_addr), 32'd2);
      idle(1, 1'b0, 2'b00);

      // Unmapped load.
      txn(32'h0000_7F20, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, rc, da, rs, gr, ge);
      chk("t3_err", 32'(ge), 32'd1);
      chk("t3_rdata", gr, 32'h0);
      chk("t3_done_at", 32'(da), 32'd1);
      chk("t3_req_cycles", 32'(rc), 32'd0);
      idle(1, 1'b0, 2'b00);

      // Timeout on dev0, then a late dev0 ack that must be ignored.
      txn(32'h0000_7F00, 1'b0, 32'h0, TO + 5, 1'b0, 32'h0, 1'b0, rc, da, rs, gr, ge);
      chk("t4_req_cycles", 32'(rc), 32'd15);
      chk("t4_err", 32'(ge), 32'd1);
      chk("t4_done_at", 32'(da), 32'd16);
      idle(1, 1'b1, 2'b00);
      idle(2, 1'b1, 2'b01);

      // dev1 targeted while dev0 acks constantly, then a back-to-back request.
      txn(32'h0000_7F14, 1'b0, 32'h0, 4, 1'b0, 32'h0, 1'b1, rc, da, rs, gr, ge);
      chk("t5_done_at", 32'(da), 32'd6);
      chk("t5_err", 32'(ge), 32'd0);
      txn(32'h0000_7F08, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0, rc, da, rs, gr, ge);
      chk("t5b_done_at", 32'(da), 32'd2);
      idle(1, 1'b0, 2'b00);

      // Reset in the middle of an ACCESS.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F08; cpu_wdata = 32'h0;
      dev_ack = 2'b00;
      e_stall = 1'b1; e_done = 1'b0; e_req = 2'b00;
      hold_exp();
      nxt();
      m_we = 1'b0; m_addr = 2'd2; m_wdata = 32'h0;
      e_stall = 1'b1; e_done = 1'b0; e_req = 2'b01;
      hold_exp();
      #1;
      chk("t6_pre_req", 32'(dev_req), 32'h1);
      chk_en = 1'b0;
      reset  = 1'b1;
      #1;
      chk("t6_async_req", 32'(dev_req), 32'h0);
      chk("t6_stall", 32'(cpu_stall), 32'd0);
      for (int i = 0; i < 2; i++) begin
         nxt();
         chk("t6_no_done", 32'(cpu_done), 32'd0);
         chk("t6_req_low", 32'(dev_req), 32'd0);
      end
      m_err = 1'b0; m_we = 1'b0; m_rdata = 32'd0; m_wdata = 32'd0; m_addr = 2'd0;
      reset  = 1'b0;
      chk_en = 1'b1;
      idle(2, 1'b0, 2'b00);
      txn(32'h0000_7F0C, 1'b0, 32'h0, 2, 1'b1, 32'h0BAD_F00D, 1'b0, rc, da, rs, gr, ge);
      chk("t6_after_rdata", gr, 32'h0BAD_F00D);
      chk("t6_after_err", 32'(ge), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         cls = $urandom_range(0, 9);
         if (cls < 4)       ad = B0 | ($urandom & 32'hF);
         else if (cls < 8)  ad = B1 | ($urandom & 32'hF);
         else if (cls == 8) ad = 32'h0000_7F20 + ($urandom & 32'hFF);
         else               ad = $urandom | 32'h8000_0000;
         r = $urandom_range(0, 9);
         if (r < 7)      ack_at = $urandom_range(0, 4);
         else if (r < 9) ack_at = $urandom_range(5, TO - 1);
         else            ack_at = TO + 5;
         txn(ad, 1'($urandom), $urandom, ack_at, 1'b0, 32'h0, 1'b0, rc, da, rs, gr, ge);
         idle($urandom_range(0, 2), 1'b0, 2'b00);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
